// File: rtl/ex_muldiv_seq_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer: op codes,
// FSM state encodings and small op-decoding helpers.
package ex_muldiv_seq_pkg;

    localparam logic [1:0] MDU_MUL  = 2'b00;
    localparam logic [1:0] MDU_MULH = 2'b01;
    localparam logic [1:0] MDU_DIV  = 2'b10;
    localparam logic [1:0] MDU_REM  = 2'b11;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'b00,
        MDU_CALC = 2'b01,
        MDU_DONE = 2'b10
    } mdu_state_e;

    // DIV and REM share the restoring-division path
    function automatic logic mdu_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    // MULH and REM both take the upper half of the accumulator
    function automatic logic mdu_hi_half(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/ex_muldiv_seq_muldiv_step.sv
// One combinational iteration of the shared accumulator: shift-add for
// multiply, restore-or-subtract and shift for unsigned division.
module ex_muldiv_seq_muldiv_step
    import ex_muldiv_seq_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [1:0]     op,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   opnd,
    output logic [2*W-1:0] acc_next
);

    logic [W:0]   sum_s;
    logic [W-1:0] shifted_lo_s;
    logic [W:0]   sub_s;
    logic         borrow_s;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide: acc = {partial remainder, remaining dividend / quotient bits}.
    always_comb begin
        sum_s        = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        shifted_lo_s = acc[2*W-2:W-1];
        sub_s        = {1'b0, shifted_lo_s} - {1'b0, opnd};
        // If the remainder MSB shifts out, the shifted value exceeds any divisor
        borrow_s     = sub_s[W] & ~acc[2*W-1];
        if (mdu_is_div(op)) begin
            if (borrow_s) begin
                acc_next = {shifted_lo_s, acc[W-2:0], 1'b0};
            end else begin
                acc_next = {sub_s[W-1:0], acc[W-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum_s, acc[W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv_seq.sv
// Iterative unsigned MUL/MULH/DIV/REM sequencer beside the EX-stage ALU.
// Holds the pipeline via stall while iterating; returns a one-cycle done pulse.
module ex_muldiv_seq
    import ex_muldiv_seq_pkg::*;
#(
    parameter int CPU_WIDTH = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [1:0]           op,
    input  logic [CPU_WIDTH-1:0] a,
    input  logic [CPU_WIDTH-1:0] b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic [CPU_WIDTH-1:0] result,
    output logic                 div_by_zero
);

    mdu_state_e             state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [2*CPU_WIDTH-1:0] acc_q, acc_d;
    logic [CPU_WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [CPU_WIDTH-1:0]   result_q, result_d;
    logic                   dbz_q, dbz_d;
    logic [2*CPU_WIDTH-1:0] step_acc_s;

    ex_muldiv_seq_muldiv_step #(.W(CPU_WIDTH)) u_muldiv_step (
        .op       (op_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_acc_s)
    );

    // Next-state, datapath loads and registered-output updates
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            MDU_IDLE: begin
                if (start && !flush) begin
                    op_d  = op;
                    cnt_d = {CNT_W{1'b0}};
                    if (mdu_is_div(op)) begin
                        opnd_d = b;
                        acc_d  = {{CPU_WIDTH{1'b0}}, a};
                    end else begin
                        opnd_d = a;
                        acc_d  = {{CPU_WIDTH{1'b0}}, b};
                    end
                    if (mdu_is_div(op) && (b == {CPU_WIDTH{1'b0}})) begin
                        state_d  = MDU_DONE;
                        done_d   = 1'b1;
                        result_d = mdu_hi_half(op) ? a : {CPU_WIDTH{1'b1}};
                        dbz_d    = 1'b1;
                    end else begin
                        state_d = MDU_CALC;
                    end
                end else begin
                    state_d = MDU_IDLE;
                end
            end
            MDU_CALC: begin
                if (flush) begin
                    state_d = MDU_IDLE;
                end else begin
                    acc_d = step_acc_s;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(CPU_WIDTH - 1)) begin
                        state_d  = MDU_DONE;
                        done_d   = 1'b1;
                        result_d = mdu_hi_half(op_q) ? step_acc_s[2*CPU_WIDTH-1:CPU_WIDTH]
                                                     : step_acc_s[CPU_WIDTH-1:0];
                        dbz_d    = 1'b0;
                    end else begin
                        state_d = MDU_CALC;
                    end
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
            default: begin
                state_d = MDU_IDLE;
            end
        endcase
        busy_d = (state_d == MDU_CALC) || (state_d == MDU_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MDU_IDLE;
            op_q     <= 2'b00;
            acc_q    <= {(2*CPU_WIDTH){1'b0}};
            opnd_q   <= {CPU_WIDTH{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {CPU_WIDTH{1'b0}};
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    // Reset gates stall so a start held through reset cannot freeze EX
    assign stall       = ~rst & (((state_q == MDU_IDLE) & start & ~flush) | (state_q == MDU_CALC));
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// Self-checking bench for ex_muldiv_seq: per-cycle comparison against a
// behavioural model, directed literal cases, flush/reset cases and random traffic.
module tb_ex_muldiv_seq;

    localparam int W = 16;

    logic         clk, rst, start, flush;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         stall, busy, done, dbz;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    ex_muldiv_seq #(.CPU_WIDTH(W), .CNT_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .stall       (stall),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Arithmetic reference straight from the operation definitions
    function automatic logic [W-1:0] ref_res(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == '0) ? {W{1'b1}} : x / y;
            default: return (y == '0) ? x : x % y;
        endcase
    endfunction

    // Model: remaining CALC cycles plus a DONE flag
    int           m_calc_left;
    logic         m_in_done, m_done, m_dbz;
    logic [W-1:0] m_result, m_pend;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_calc_left <= 0;
            m_in_done   <= 1'b0;
            m_done      <= 1'b0;
            m_dbz       <= 1'b0;
            m_result    <= '0;
            m_pend      <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_in_done) begin
                m_in_done <= 1'b0;
            end else if (m_calc_left > 0) begin
                if (flush) begin
                    m_calc_left <= 0;
                end else begin
                    m_calc_left <= m_calc_left - 1;
                    if (m_calc_left == 1) begin
                        m_in_done <= 1'b1;
                        m_done    <= 1'b1;
                        m_result  <= m_pend;
                        m_dbz     <= 1'b0;
                    end
                end
            end else if (start && !flush) begin
                if (op[1] && b == '0) begin
                    m_in_done <= 1'b1;
                    m_done    <= 1'b1;
                    m_result  <= ref_res(op, a, b);
                    m_dbz     <= 1'b1;
                end else begin
                    m_calc_left <= W;
                    m_pend      <= ref_res(op, a, b);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model
    task automatic tick();
        logic m_idle, exp_stall;
        @(negedge clk);
        m_idle    = (m_calc_left == 0) && !m_in_done;
        exp_stall = !rst && ((m_idle && start && !flush) || (m_calc_left > 0));
        chk("busy",   32'(busy),   32'(!m_idle));
        chk("done",   32'(done),   32'(m_done));
        chk("stall",  32'(stall),  32'(exp_stall));
        chk("result", 32'(result), 32'(m_result));
        chk("dbz",    32'(dbz),    32'(m_dbz));
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_res, input logic exp_dz, input int exp_lat);
        logic seen;
        seen  = 1'b0;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1 chk("stall_start", 32'(stall), 32'd1);
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
                chk("latency", 32'(k), 32'(exp_lat));
                chk("res_lit", 32'(result), 32'(exp_res));
                chk("dz_lit",  32'(dbz), 32'(exp_dz));
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
        tick();
    endtask

    initial begin
        logic any_done;
        logic seen;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        tick();
        tick();
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy",   32'(busy),   32'd0);
        rst = 1'b0;
        tick();

        run_op(2'b00, 16'd300,   16'd200,  16'hEA60, 1'b0, 17);
        run_op(2'b01, 16'd300,   16'd200,  16'h0000, 1'b0, 17);
        run_op(2'b00, 16'hFFFF,  16'hFFFF, 16'h0001, 1'b0, 17);
        run_op(2'b01, 16'hFFFF,  16'hFFFF, 16'hFFFE, 1'b0, 17);
        run_op(2'b10, 16'd100,   16'd7,    16'd14,   1'b0, 17);
        run_op(2'b11, 16'd100,   16'd7,    16'd2,    1'b0, 17);
        run_op(2'b10, 16'h0005,  16'h0009, 16'h0000, 1'b0, 17);
        run_op(2'b11, 16'h0005,  16'h0009, 16'h0005, 1'b0, 17);
        run_op(2'b10, 16'h1234,  16'h0000, 16'hFFFF, 1'b1, 1);
        run_op(2'b11, 16'h1234,  16'h0000, 16'h1234, 1'b1, 1);

        // Flush on the 5th CALC cycle of DIV 100/7
        start = 1'b1; op = 2'b10; a = 16'd100; b = 16'd7;
        for (int k = 1; k <= 5; k++) tick();
        start = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_idle", 32'(busy), 32'd0);
        any_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            any_done = any_done | done;
        end
        chk("flush_nodone", 32'(any_done), 32'd0);
        chk("flush_hold", 32'(result), 32'h1234);
        run_op(2'b00, 16'd3, 16'd4, 16'd12, 1'b0, 17);

        // Asynchronous reset mid-CALC, then start held across reset release
        start = 1'b1; op = 2'b00; a = 16'd7; b = 16'd9;
        for (int k = 1; k <= 6; k++) tick();
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",   32'(busy),   32'd0);
        chk("arst_done",   32'(done),   32'd0);
        chk("arst_result", 32'(result), 32'd0);
        chk("arst_stall",  32'(stall),  32'd0);
        start = 1'b1; op = 2'b00; a = 16'd5; b = 16'd6;
        for (int k = 0; k < 3; k++) tick();
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            tick();
            if (done) begin
                seen  = 1'b1;
                start = 1'b0;
                chk("rel_latency", 32'(k), 32'd17);
                chk("rel_result",  32'(result), 32'd30);
            end
        end
        start = 1'b0;
        chk("rel_done_seen", 32'(seen), 32'd1);
        tick();

        // Random traffic, including start while busy, b==0 and stray flushes
        for (int k = 0; k < 3000; k++) begin
            tick();
            start = ($urandom_range(0, 3) != 0);
            op    = 2'($urandom_range(0, 3));
            a     = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = 16'($urandom_range(1, 15));
                default: b = 16'($urandom);
            endcase
            flush = ($urandom_range(0, 49) == 0);
        end
        start = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < 20; k++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
